// File: rtl/bcd_pkg.sv
// Shared BCD constants and the load-value clamp used by the tick counter.
package bcd_pkg;
  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// One combinational BCD digit stepper; chained so carry/borrow ripples in one cycle.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             up_dn,
  input  logic             carry_in,
  output logic [BCD_W-1:0] digit_nxt,
  output logic             carry_out
);
  always_comb begin
    digit_nxt = digit;
    carry_out = 1'b0;
    if (carry_in) begin
      if (up_dn) begin
        if (digit >= BCD_MAX) begin
          digit_nxt = BCD_MIN;
          carry_out = 1'b1;
        end else begin
          digit_nxt = digit + 4'd1;
        end
      end else if (digit == BCD_MIN) begin
        digit_nxt = BCD_MAX;
        carry_out = 1'b1;
      end else begin
        digit_nxt = digit - 4'd1;
      end
    end
  end
endmodule

// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD up/down counter stepped by synchronized rising edges of tick_in.
module bcd_tick_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_in,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  step
);
  logic [SYNC_STAGES-1:0]           sync_q, sync_d;
  logic [SYNC_STAGES-1:0]           vld_pipe_q, vld_pipe_d;
  logic                             hist_q, hist_d;
  logic                             armed_q, armed_d;
  logic                             step_q, step_d;
  logic                             wrap_q, wrap_d;
  logic [DIGITS-1:0][BCD_W-1:0]     count_q, count_d;
  logic [DIGITS-1:0][BCD_W-1:0]     digit_nxt;
  logic [DIGITS:0]                  carry;
  logic                             tick_s, tick_vld;

  assign tick_s   = sync_q[SYNC_STAGES-1];
  // vld_pipe marks when the synchronizer holds a real post-reset sample,
  // so the reset-cleared zeros cannot arm the edge detector.
  assign tick_vld = vld_pipe_q[SYNC_STAGES-1];

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], tick_in};
    vld_pipe_d = {vld_pipe_q[SYNC_STAGES-2:0], 1'b1};
    hist_d     = tick_s;
    armed_d    = armed_q | (tick_vld & ~tick_s);
    step_d     = armed_q & tick_s & ~hist_q;
  end

  assign carry[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .digit     (count_q[g]),
      .up_dn     (up_dn),
      .carry_in  (carry[g]),
      .digit_nxt (digit_nxt[g]),
      .carry_out (carry[g+1])
    );
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      for (int i = 0; i < DIGITS; i++)
        count_d[i] = bcd_clamp(load_val[i*BCD_W +: BCD_W]);
    end else if (step_q && en) begin
      count_d = digit_nxt;
      wrap_d  = carry[DIGITS];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      vld_pipe_q <= '0;
      hist_q     <= 1'b0;
      armed_q    <= 1'b0;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      sync_q     <= sync_d;
      vld_pipe_q <= vld_pipe_d;
      hist_q     <= hist_d;
      armed_q    <= armed_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
      count_q    <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign step  = step_q;
endmodule

// File: tb/tb_bcd_tick_counter.sv
// Randomized and directed bench for bcd_tick_counter against an integer-valued model.
module tb_bcd_tick_counter;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MODV   = 10000;

  logic         clk = 1'b0, rst = 1'b0, tick_in = 1'b0;
  logic         en = 1'b0, up_dn = 1'b1, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         wrap, step;

  int total = 0, bad = 0;

  // Model: tick_in samples since reset release, count as a plain integer.
  bit samples[$];
  int mv    = 0;
  bit mwrap = 1'b0;
  bit mstep = 1'b0;

  bcd_tick_counter #(.DIGITS(DIGITS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .en(en), .up_dn(up_dn),
    .load(load), .load_val(load_val), .count(count), .wrap(wrap), .step(step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    int r = 0;
    for (int i = 0; i < DIGITS; i++) begin
      r |= (v % 10) << (4 * i);
      v /= 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [W-1:0] lv);
    int r = 0, p = 1, d;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'((lv >> (4 * i)) & 16'hF);
      if (d > 9) d = 9;
      r += d * p;
      p *= 10;
    end
    return r;
  endfunction

  // One clock: advance the model on the edge, check the DUT 1ns later.
  task automatic cyc();
    int k;
    @(posedge clk);
    samples.push_back(tick_in);
    k = samples.size();
    if (load) begin
      mv = clamp_val(load_val); mwrap = 1'b0;
    end else if (mstep && en) begin
      if (up_dn) begin mwrap = (mv == MODV - 1); mv = (mv + 1) % MODV; end
      else       begin mwrap = (mv == 0);        mv = (mv + MODV - 1) % MODV; end
    end else begin
      mwrap = 1'b0;
    end
    // A step follows a low-then-high pair of post-reset samples, two samples later.
    mstep = (k >= 4) && samples[k-3] && !samples[k-4];
    #1;
    chk("count", 32'(count), 32'(to_bcd(mv)));
    chk("wrap",  32'(wrap),  32'(mwrap));
    chk("step",  32'(step),  32'(mstep));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_wrap",  32'(wrap),  32'h0);
    chk("rst_step",  32'(step),  32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    samples.delete();
    mv = 0; mwrap = 1'b0; mstep = 1'b0;
  endtask

  task automatic tick(input int hold);
    tick_in = 1'b1; repeat (hold) cyc();
    tick_in = 1'b0; repeat (hold) cyc();
  endtask

  task automatic wait_step();
    int n = 0;
    while (!mstep && n < 20) begin cyc(); n++; end
    chk("step_seen", 32'(step), 32'h1);
  endtask

  initial begin
    // Tick high through reset must not produce a step.
    tick_in = 1'b1;
    do_reset();
    repeat (10) cyc();
    tick_in = 1'b0; repeat (3) cyc();
    en = 1'b1; up_dn = 1'b1;
    tick(3);
    chk("first_tick", 32'(count), 32'h0001);

    load = 1'b1; load_val = 16'h0998; cyc(); load = 1'b0;
    tick(3); tick(3);
    chk("ld998_up2", 32'(count), 32'h1000);

    load = 1'b1; load_val = 16'h9999; cyc(); load = 1'b0;
    tick(3);
    up_dn = 1'b0; tick(3);
    chk("wrap_down", 32'(count), 32'h9999);

    load = 1'b1; load_val = 16'h1000; cyc(); load = 1'b0;
    tick(3);
    en = 1'b0; tick(3); tick(3); tick(3);
    chk("en_hold", 32'(count), 32'h0999);

    // Load coincident with a step wins and clamps each digit.
    en = 1'b1; up_dn = 1'b1; tick_in = 1'b1;
    wait_step();
    load = 1'b1; load_val = 16'hA3F5; cyc(); load = 1'b0;
    chk("ld_clamp", 32'(count), 32'h9395);
    tick_in = 1'b0; repeat (4) cyc();

    // Reset one cycle after a step clears immediately and disarms.
    tick_in = 1'b1;
    wait_step();
    cyc();
    do_reset();
    repeat (6) cyc();
    chk("post_rst", 32'(count), 32'h0000);

    repeat (80) begin
      int hold;
      hold    = int'($urandom_range(3, 6));
      en      = ($urandom_range(0, 3) != 0);
      tick_in = ~tick_in;
      if ($urandom_range(0, 6) == 0) begin
        load = 1'b1; load_val = W'($urandom);
      end
      repeat (hold) begin
        up_dn = 1'($urandom_range(0, 1));
        cyc();
        load = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
